// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver, transmitter and the receive-side byte FIFO.
package uart_pkg;
  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read and occupancy count.
// A push while full is still accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop_req,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       dropped
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop, wr_en;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;

  assign pop     = out_valid & pop_req;
  assign wr_en   = push & (~full | pop);
  assign dropped = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous accept and pop leaves occupancy unchanged.
    if (wr_en && !pop)      count_d = count_q + 1'b1;
    else if (!wr_en && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; out_data is meaningless while empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer: turns the receiver's level valid into one push per byte,
// buffers up to DEPTH bytes and keeps a sticky overflow flag for dropped bytes.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RX_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  input  logic                   clr_overflow
);
  logic in_valid_q, in_valid_d;
  logic overflow_q, overflow_d;
  logic push, dropped;

  assign push       = in_valid & ~in_valid_q;
  assign in_valid_d = in_valid;
  assign overflow   = overflow_q;

  always_comb begin
    overflow_d = overflow_q;
    if (dropped)           overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // in_valid_q resets high so a level already asserted at reset release is not a push.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      in_valid_q <= in_valid_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop_req   (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .dropped   (dropped)
  );
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_uart_rx_fifo;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst, in_valid, out_ready, clr_overflow;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, full, empty, overflow;
  logic [DATA_W-1:0] out_data;
  logic [4:0]        count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mq[$];
  bit         m_prev = 1'b1;
  bit         m_ovf  = 1'b0;

  uart_rx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_overflow(clr_overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour: one byte per rising edge of in_valid, FIFO order, drop when full without a pop.
  function automatic void model_step();
    bit push, pop;
    int sz;
    if (rst) begin
      mq.delete();
      m_prev = 1'b1;
      m_ovf  = 1'b0;
      return;
    end
    sz   = mq.size();
    push = in_valid && !m_prev;
    pop  = (sz > 0) && out_ready;
    if (pop) void'(mq.pop_front());
    if (push && (sz < DEPTH || pop)) mq.push_back(in_data);
    if (push && sz == DEPTH && !pop) m_ovf = 1'b1;
    else if (clr_overflow)           m_ovf = 1'b0;
    m_prev = in_valid;
  endfunction

  task automatic check_all();
    chk("count", 32'(count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (mq.size() != 0) chk("out_data", 32'(out_data), 32'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int hi_left, lo_left;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_overflow = 1'b0;
    #1;
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    rst = 1'b0;
    tick();

    // Long level valid produces exactly one byte.
    in_data = 8'hA5; in_valid = 1'b1;
    tick();
    chk("t1_valid_next", 32'(out_valid), 32'd1);
    repeat (433) tick();
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_data", 32'(out_data), 32'hA5);
    in_valid = 1'b0;

    // Level held through reset release is ignored.
    in_valid = 1'b1;
    do_reset();
    repeat (100) tick();
    chk("t2_count0", 32'(count), 32'd0);
    in_valid = 1'b0; tick();
    send(8'h3C);
    chk("t2_count1", 32'(count), 32'd1);
    chk("t2_data", 32'(out_data), 32'h3C);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill, drop one, drain in order.
    for (int i = 0; i < 16; i++) send(8'(i));
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_count", 32'(count), 32'd16);
    send(8'h55);
    chk("t3_ovf", 32'(overflow), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", 32'(out_data), 32'(i));
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty", 32'(empty), 32'd1);

    // Push while full with a simultaneous pop is accepted.
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h40 + i));
    in_data = 8'h99; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_count", 32'(count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd0);
    out_ready = 1'b1;
    repeat (15) tick();
    chk("t4_last", 32'(out_data), 32'h99);
    tick();
    out_ready = 1'b0;

    // Drop wins over a simultaneous clear; a lone clear then takes effect.
    for (int i = 0; i < 16; i++) send(8'(8'hC0 + i));
    send(8'hEE);
    chk("t5_set", 32'(overflow), 32'd1);
    in_data = 8'hEF; in_valid = 1'b1; clr_overflow = 1'b1;
    tick();
    in_valid = 1'b0; clr_overflow = 1'b0;
    chk("t5_keep", 32'(overflow), 32'd1);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t5_clr", 32'(overflow), 32'd0);

    // Interleaved traffic wrapping the pointers, reset midway.
    out_ready = 1'b1; repeat (10) tick(); out_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h80 + i));
      if (i % 2 == 1) begin out_ready = 1'b1; tick(); out_ready = 1'b0; end
      if (i == 9) begin
        do_reset();
        tick();
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_empty", 32'(empty), 32'd1);
        chk("t6_ovf", 32'(overflow), 32'd0);
      end
    end
    out_ready = 1'b1; repeat (12) tick(); out_ready = 1'b0;
    send(8'h7E);
    chk("t6_data", 32'(out_data), 32'h7E);

    // Random traffic: level-style valid with random high/low lengths.
    hi_left = 0; lo_left = 2;
    for (int c = 0; c < 4000; c++) begin
      if (in_valid) begin
        if (hi_left == 0) begin in_valid = 1'b0; lo_left = $urandom_range(1, 4); end
        else hi_left--;
      end else begin
        if (lo_left == 0) begin
          in_valid = 1'b1; in_data = 8'($urandom); hi_left = $urandom_range(0, 6);
        end else lo_left--;
      end
      out_ready    = ($urandom_range(0, 99) < 35);
      clr_overflow = ($urandom_range(0, 99) < 3);
      rst          = ($urandom_range(0, 999) < 2);
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_overflow = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
